// File: rtl/ctrl_multiciclo.sv
// Multi-cycle MIPS main control: sequences FETCH/DECODE/EXECUTE/MEM/WB and
// decodes datapath selects, write enables and ALUOp from the current state.
module ctrl_multiciclo (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_LOG = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXEC_R   = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_IMM_EX   = 4'd8,
    S_IMM_WB   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JR       = 4'd12
  } state_t;

  state_t cur, nxt;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) cur <= S_FETCH;
    else       cur <= nxt;
  end

  assign state = cur;

  // NOTE: nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:                      nxt = S_MEMADR;
          OP_RTYPE:                          nxt = (funct == FN_JR) ? S_JR : S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: nxt = S_IMM_EX;
          OP_BEQ, OP_BNE:                    nxt = S_BRANCH;
          OP_J, OP_JAL:                      nxt = S_JUMP;
          default:                           nxt = S_FETCH;
        endcase
      end
      S_MEMADR: nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nxt = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  nxt = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC_R: nxt = S_RTYPE_WB;
      S_IMM_EX: nxt = S_IMM_WB;
      default:  nxt = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 2'b00;
    MemtoReg   = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = ALU_ADD;
    PCSource   = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (cur)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
          OP_BEQ, OP_BNE, OP_J, OP_JAL: ;
          default: begin
            illegal    = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 2'b01;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_R;
      end
      S_RTYPE_WB: begin
        RegWrite   = 1'b1;
        RegDst     = 2'b01;
        instr_done = 1'b1;
      end
      S_IMM_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = (opcode == OP_ADDI) ? ALU_ADD : ALU_LOG;
      end
      S_IMM_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUOp      = ALU_SUB;
        PCSource   = 2'b01;
        PCWrite    = (opcode == OP_BNE) ? ~zero : zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        PCSource   = 2'b10;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
        if (opcode == OP_JAL) begin
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          MemtoReg = 2'b10;
        end
      end
      S_JR: begin
        ALUSrcA    = 1'b1;
        ALUOp      = ALU_R;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase

    // While reset is high the in-flight instruction is dropped: show idle FETCH, no writes.
    if (reset) begin
      PCWrite    = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b1;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      RegDst     = 2'b00;
      MemtoReg   = 2'b00;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b01;
      ALUOp      = ALU_ADD;
      PCSource   = 2'b00;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_ctrl_multiciclo.sv
// Scoreboard bench for ctrl_multiciclo: each driven cycle queues its expected
// control vector; a negedge monitor pops and compares against the DUT outputs.
module tb_ctrl_multiciclo;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0] RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource;
  logic       ALUSrcA, instr_done, illegal;
  logic [3:0] state;

  typedef struct packed {
    logic       pcwrite;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state;
  } ctl_t;

  ctl_t  exp_q[$];
  bit    cs_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail = 0;

  ctrl_multiciclo dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input ctl_t act, input ctl_t exp, input bit chk_state);
    ctl_t a;
    a = act;
    if (!chk_state) a.state = exp.state;
    n_checks++;
    if (a !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (fields pcw,iord,mrd,mwr,irw,rw,rdst,m2r,srca,srcb,aluop,pcsrc,done,ill,state)",
               nm, a, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents one control vector, compared against the queue head.
  initial begin
    ctl_t act, e;
    bit cs;
    string nm;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        cs = cs_q.pop_front();
        nm = name_q.pop_front();
        act = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
               ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal, state};
        check(nm, act, e, cs);
      end
    end
  end

  task automatic step(input logic rst, input logic mr, input logic zf,
                      input logic [5:0] op, input logic [5:0] fn,
                      input ctl_t e, input bit cs, input string nm);
    @(posedge clock);
    #1;
    reset = rst; mem_ready = mr; zero = zf; opcode = op; funct = fn;
    exp_q.push_back(e);
    cs_q.push_back(cs);
    name_q.push_back(nm);
  endtask

  function automatic ctl_t st(input logic [3:0] s);
    ctl_t c;
    c = '0;
    c.state = s;
    return c;
  endfunction

  function automatic ctl_t fetch_v(input logic mr);
    ctl_t c;
    c = st(4'd0);
    c.memread = 1'b1;
    c.alusrcb = 2'b01;
    c.pcwrite = mr;
    c.irwrite = mr;
    return c;
  endfunction

  function automatic ctl_t decode_v();
    ctl_t c;
    c = st(4'd1);
    c.alusrcb = 2'b11;
    return c;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    ctl_t e;
    // Reset held for two cycles with mem_ready high.
    step(1, 1, 0, 6'h23, 6'h00, fetch_v(0), 1, "reset_c1");
    step(1, 1, 0, 6'h23, 6'h00, fetch_v(0), 1, "reset_c2");

    // lw, no wait states: 0,1,2,3,4
    step(0, 1, 0, 6'h23, 6'h00, fetch_v(1), 1, "lw_fetch");
    step(0, 1, 0, 6'h23, 6'h00, decode_v(), 1, "lw_decode");
    e = st(4'd2); e.alusrca = 1; e.alusrcb = 2'b10;
    step(0, 1, 0, 6'h23, 6'h00, e, 1, "lw_memadr");
    e = st(4'd3); e.iord = 1; e.memread = 1;
    step(0, 1, 0, 6'h23, 6'h00, e, 1, "lw_memrd");
    e = st(4'd4); e.regwrite = 1; e.memtoreg = 2'b01; e.instr_done = 1;
    step(0, 1, 0, 6'h23, 6'h00, e, 1, "lw_memwb");

    // sw with two wait states in MEMWR
    step(0, 1, 0, 6'h2B, 6'h00, fetch_v(1), 1, "sw_fetch");
    step(0, 1, 0, 6'h2B, 6'h00, decode_v(), 1, "sw_decode");
    e = st(4'd2); e.alusrca = 1; e.alusrcb = 2'b10;
    step(0, 1, 0, 6'h2B, 6'h00, e, 1, "sw_memadr");
    e = st(4'd5); e.iord = 1; e.memwrite = 1;
    step(0, 0, 0, 6'h2B, 6'h00, e, 1, "sw_memwr_wait1");
    step(0, 0, 0, 6'h2B, 6'h00, e, 1, "sw_memwr_wait2");
    e.instr_done = 1;
    step(0, 1, 0, 6'h2B, 6'h00, e, 1, "sw_memwr_done");

    // add with one FETCH wait state
    step(0, 0, 0, 6'h00, 6'h20, fetch_v(0), 1, "add_fetch_wait");
    step(0, 1, 0, 6'h00, 6'h20, fetch_v(1), 1, "add_fetch");
    step(0, 1, 0, 6'h00, 6'h20, decode_v(), 1, "add_decode");
    e = st(4'd6); e.alusrca = 1; e.aluop = 2'b10;
    step(0, 1, 0, 6'h00, 6'h20, e, 1, "add_exec_r");
    e = st(4'd7); e.regwrite = 1; e.regdst = 2'b01; e.instr_done = 1;
    step(0, 1, 0, 6'h00, 6'h20, e, 1, "add_rtype_wb");

    // jr
    step(0, 1, 0, 6'h00, 6'h08, fetch_v(1), 1, "jr_fetch");
    step(0, 1, 0, 6'h00, 6'h08, decode_v(), 1, "jr_decode");
    e = st(4'd12); e.alusrca = 1; e.aluop = 2'b10; e.pcwrite = 1; e.instr_done = 1;
    step(0, 1, 0, 6'h00, 6'h08, e, 1, "jr_exec");

    // beq taken, bne not taken (zero=1 for both)
    step(0, 1, 1, 6'h04, 6'h00, fetch_v(1), 1, "beq_fetch");
    step(0, 1, 1, 6'h04, 6'h00, decode_v(), 1, "beq_decode");
    e = st(4'd10); e.alusrca = 1; e.aluop = 2'b01; e.pcsource = 2'b01; e.instr_done = 1; e.pcwrite = 1;
    step(0, 1, 1, 6'h04, 6'h00, e, 1, "beq_branch");
    step(0, 1, 1, 6'h05, 6'h00, fetch_v(1), 1, "bne_fetch");
    step(0, 1, 1, 6'h05, 6'h00, decode_v(), 1, "bne_decode");
    e.pcwrite = 0;
    step(0, 1, 1, 6'h05, 6'h00, e, 1, "bne_branch_z1");
    step(0, 1, 0, 6'h05, 6'h00, fetch_v(1), 1, "bne2_fetch");
    step(0, 1, 0, 6'h05, 6'h00, decode_v(), 1, "bne2_decode");
    e.pcwrite = 1;
    step(0, 1, 0, 6'h05, 6'h00, e, 1, "bne_branch_z0");

    // addi then ori
    step(0, 1, 0, 6'h08, 6'h00, fetch_v(1), 1, "addi_fetch");
    step(0, 1, 0, 6'h08, 6'h00, decode_v(), 1, "addi_decode");
    e = st(4'd8); e.alusrca = 1; e.alusrcb = 2'b10; e.aluop = 2'b00;
    step(0, 1, 0, 6'h08, 6'h00, e, 1, "addi_imm_ex");
    e = st(4'd9); e.regwrite = 1; e.instr_done = 1;
    step(0, 1, 0, 6'h08, 6'h00, e, 1, "addi_imm_wb");
    step(0, 1, 0, 6'h0D, 6'h00, fetch_v(1), 1, "ori_fetch");
    step(0, 1, 0, 6'h0D, 6'h00, decode_v(), 1, "ori_decode");
    e = st(4'd8); e.alusrca = 1; e.alusrcb = 2'b10; e.aluop = 2'b11;
    step(0, 1, 0, 6'h0D, 6'h00, e, 1, "ori_imm_ex");
    e = st(4'd9); e.regwrite = 1; e.instr_done = 1;
    step(0, 1, 0, 6'h0D, 6'h00, e, 1, "ori_imm_wb");

    // jal, then j
    step(0, 1, 0, 6'h03, 6'h00, fetch_v(1), 1, "jal_fetch");
    step(0, 1, 0, 6'h03, 6'h00, decode_v(), 1, "jal_decode");
    e = st(4'd11); e.pcsource = 2'b10; e.pcwrite = 1; e.instr_done = 1;
    e.regwrite = 1; e.regdst = 2'b10; e.memtoreg = 2'b10;
    step(0, 1, 0, 6'h03, 6'h00, e, 1, "jal_jump");
    step(0, 1, 0, 6'h02, 6'h00, fetch_v(1), 1, "j_fetch");
    step(0, 1, 0, 6'h02, 6'h00, decode_v(), 1, "j_decode");
    e = st(4'd11); e.pcsource = 2'b10; e.pcwrite = 1; e.instr_done = 1;
    step(0, 1, 0, 6'h02, 6'h00, e, 1, "j_jump");

    // Illegal opcode: two cycles, back to FETCH
    step(0, 1, 0, 6'h3F, 6'h00, fetch_v(1), 1, "ill_fetch");
    e = decode_v(); e.illegal = 1; e.instr_done = 1;
    step(0, 1, 0, 6'h3F, 6'h00, e, 1, "ill_decode");

    // jal abandoned by reset in its JUMP cycle: no write enables, then clean FETCH
    step(0, 1, 0, 6'h03, 6'h00, fetch_v(1), 1, "rst_jal_fetch");
    step(0, 1, 0, 6'h03, 6'h00, decode_v(), 1, "rst_jal_decode");
    step(1, 1, 0, 6'h03, 6'h00, fetch_v(0), 0, "rst_mid_jump");
    step(0, 1, 0, 6'h23, 6'h00, fetch_v(1), 1, "post_rst_fetch");
    step(0, 1, 0, 6'h23, 6'h00, decode_v(), 1, "post_rst_decode");

    @(negedge clock);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_multiciclo.md
# ctrl_multiciclo

Multi-cycle main control unit for the MIPS datapath. It replaces the single-cycle decoder and sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB states. Every cycle it drives the datapath mux selects, the register-file, memory and PC write enables, and the 2-bit `ALUOp` consumed by `ula_ctrl`. Memory accesses use a ready handshake, so the unit tolerates wait states.

## Interface
- No parameters. Opcode, funct and ALUOp encodings come from `defines.vh`.
- `clock  in  1  system clock, rising edge`
- `reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high`
- `opcode  in  6  IR[31:26], valid from DECODE onward`
- `funct  in  6  IR[5:0]`
- `zero  in  1  ALU zero flag, same cycle`
- `mem_ready  in  1  memory completes the current read/write this cycle`
- `PCWrite  out  1`; `IorD  out  1`; `MemRead  out  1`; `MemWrite  out  1`; `IRWrite  out  1`; `RegWrite  out  1`
- `RegDst  out  2  00 rt, 01 rd, 10 $31`
- `MemtoReg  out  2  00 ALUOut, 01 MDR, 10 PC`
- `ALUSrcA  out  1  0 PC, 1 reg A`
- `ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2`
- `ALUOp  out  2  00 add (LW_SW_ADDI), 01 sub (BEQ_BNE), 10 R-type, 11 logical immediate`
- `PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target`
- `instr_done  out  1  pulse in the last cycle of each instruction`
- `illegal  out  1  pulse on an unsupported opcode`
- `state  out  4  current state code, for debug`

## Operation
- Moore FSM with a 4-bit state register. Outputs decode combinationally from the state, plus the Mealy terms listed below. Any output not listed for a state is 0.
- State codes:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, RTYPE_WB=7
  - IMM_EX=8, IMM_WB=9, BRANCH=10, JUMP=11, JR=12
  - Codes 13–15 go to FETCH on the next cycle.
- FETCH: MemRead=1, ALUSrcB=01, ALUOp=00.
  - IRWrite and PCWrite are each equal to mem_ready.
  - Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE: ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - 0x23 (lw) or 0x2B (sw): MEMADR
  - 0x00 with funct 0x08 (jr): JR
  - 0x00 with any other funct: EXEC_R
  - 0x08, 0x0C, 0x0D, 0x0E (addi/andi/ori/xori): IMM_EX
  - 0x04, 0x05 (beq/bne): BRANCH
  - 0x02, 0x03 (j/jal): JUMP
  - Any other opcode: FETCH, with illegal=1 and instr_done=1.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1, MemRead=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: RegWrite=1, RegDst=00, MemtoReg=01, instr_done=1. Next is FETCH.
- MEMWR: IorD=1, MemWrite=1. Hold until mem_ready; then instr_done=1 and next is FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next is RTYPE_WB.
- RTYPE_WB: RegWrite=1, RegDst=01, MemtoReg=00, instr_done=1. Next is FETCH.
- IMM_EX: ALUSrcA=1, ALUSrcB=10. ALUOp=00 for addi, 11 otherwise. Next is IMM_WB.
- IMM_WB: RegWrite=1, RegDst=00, MemtoReg=00, instr_done=1. Next is FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, instr_done=1. Next is FETCH.
  - PCWrite = zero for beq, ~zero for bne.
- JUMP: PCSource=10, PCWrite=1, instr_done=1. Next is FETCH.
  - For jal also RegWrite=1, RegDst=10, MemtoReg=10 (PC already holds PC+4).
- JR: ALUSrcA=1, ALUOp=10 (ula_ctrl maps funct jr to pass A), PCSource=00, PCWrite=1, instr_done=1. Next is FETCH.
- opcode and funct are sampled combinationally in every state. The datapath holds IR stable between IRWrite pulses.

## Timing
- Reset: the state register becomes FETCH on the next rising edge while reset=1.
- Outputs during and just after reset are the FETCH values: MemRead=1, ALUSrcB=01, every other output 0.
  - IRWrite and PCWrite stay 0 while reset=1, regardless of mem_ready.
- Reset mid-instruction: the instruction is abandoned. No write enable may be asserted in the cycle reset is high.
- Latency with mem_ready tied to 1:
  - lw 5 cycles
  - sw, R-type, immediate: 4 cycles each
  - beq/bne, j/jal, jr: 3 cycles each
  - illegal opcode: 2 cycles
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. Control outputs stay constant while waiting.
- instr_done and illegal are exactly 1 cycle wide per instruction.
- PCWrite asserts in at most one cycle per instruction outside FETCH.

## Test plan
- Reset held 2 cycles with mem_ready=1 -> state=0, MemRead=1, ALUSrcB=01, PCWrite=IRWrite=0. First post-reset cycle: PCWrite=IRWrite=1.
- lw (0x23), mem_ready=1 -> states 0,1,2,3,4. MEMWB has RegWrite=1 and MemtoReg=01; instr_done high only in cycle 5.
- sw (0x2B) with mem_ready low for 2 cycles in MEMWR -> MemWrite high 3 cycles, total 6 cycles, RegWrite never 1.
- add (op 0, funct 0x20), then jr (funct 0x08) -> EXEC_R ALUOp=10 then RTYPE_WB RegDst=01. jr takes 3 cycles with PCWrite=1, PCSource=00.
- beq with zero=1, then bne with zero=1 -> BRANCH PCWrite=1, then PCWrite=0. Both have PCSource=01 and ALUOp=01.
- jal (0x03) -> JUMP with RegDst=10, MemtoReg=10, RegWrite=1, PCWrite=1. Then opcode 0x3F -> illegal=1 in DECODE, state returns to 0.
